// File: rtl/alu.sv
// 64-bit ALU (ADD/SUB/AND/OR) with registered result and Z/N/C/V flags.
// One shared adder serves ADD and SUB, and there is one cycle of latency at full throughput.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  Control,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        in_valid,
   output logic [63:0] y,
   output logic        out_valid,
   output logic        zero,
   output logic        negative,
   output logic        carry,
   output logic        overflow
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   op_e         op;
   logic        sub;
   logic [63:0] b_add;
   logic [64:0] sum;

   logic [63:0] y_d,        y_q;
   logic        carry_d,    carry_q;
   logic        overflow_d, overflow_q;
   logic        valid_q;
   logic        zero_q;
   logic        negative_q;

   assign op  = op_e'(Control);
   assign sub = (op == OP_SUB);

   // SUB is a + ~b + 1: invert b and feed the +1 in as the carry-in.
   assign b_add = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_add} + {64'd0, sub};

   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path can infer a latch.
      y_d        = sum[63:0];
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            carry_d    = sum[64];
            overflow_d = (a[63] == b_add[63]) && (sum[63] != a[63]);
         end
         OP_AND:  y_d = a & b;
         OP_OR:   y_d = a | b;
         default: y_d = sum[63:0];
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q        <= '0;
         valid_q    <= 1'b0;
         zero_q     <= 1'b1;
         negative_q <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         y_q        <= y_d;
         valid_q    <= in_valid;
         zero_q     <= (y_d == 64'd0);
         negative_q <= y_d[63];
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
      end
   end

   assign y         = y_q;
   assign out_valid = valid_q;
   assign zero      = zero_q;
   assign negative  = negative_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary vectors plus random traffic,
// compared against an arithmetic reference model of the four operations.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [1:0]  control;
   logic [63:0] a;
   logic [63:0] b;
   logic        in_valid;
   logic [63:0] y;
   logic        out_valid;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Control   (control),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .y         (y),
      .out_valid (out_valid),
      .zero      (zero),
      .negative  (negative),
      .carry     (carry),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] y;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
   } res_t;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        valid;
      logic        lit;
      logic [63:0] y;
   } vec_t;

   localparam logic signed [127:0] SMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] SMIN = -SMAX - 128'sd1;

   localparam int NV = 20;
   vec_t vecs [NV] = '{
      '{2'b00, 64'd1029, 64'd1027, 1'b1, 1'b1, 64'd2056},
      '{2'b01, 64'd1029, 64'd1027, 1'b1, 1'b1, 64'd2},
      '{2'b10, 64'd1029, 64'd1027, 1'b1, 1'b1, 64'd1025},
      '{2'b11, 64'd1029, 64'd1027, 1'b1, 1'b1, 64'd1031},
      '{2'b00, 64'h5D9F, 64'hF0CB2, 1'b1, 1'b1, 64'hF6A51},
      '{2'b01, 64'h5D9F, 64'hF0CB2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFF1_50ED},
      '{2'b10, 64'h5D9F, 64'hF0CB2, 1'b1, 1'b1, 64'h0C92},
      '{2'b11, 64'h5D9F, 64'hF0CB2, 1'b1, 1'b1, 64'hF5DBF},
      '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 64'h8000_0000_0000_0000},
      '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 64'd0},
      '{2'b01, 64'h1234, 64'h1234, 1'b1, 1'b1, 64'd0},
      '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF},
      '{2'b00, 64'hFFF3_C038_0000_0000, 64'hFFFF_F7ED_0000_0000, 1'b1, 1'b1, 64'hFFF3_B825_0000_0000},
      '{2'b01, 64'hFFF3_C038_0000_0000, 64'hFFFF_F7ED_0000_0000, 1'b1, 1'b1, 64'hFFF3_C84B_0000_0000},
      '{2'b10, 64'hFFF3_C038_0000_0000, 64'hFFFF_F7ED_0000_0000, 1'b0, 1'b0, 64'd0},
      '{2'b10, 64'hFFF3_C038_0000_0000, 64'hFFFF_F7ED_0000_0000, 1'b1, 1'b0, 64'd0},
      '{2'b11, 64'hFFF3_C038_0000_0000, 64'hFFFF_F7ED_0000_0000, 1'b1, 1'b0, 64'd0},
      '{2'b01, 64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF},
      '{2'b11, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0},
      '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 64'd0}
   };

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // Reference: carries from unsigned comparisons, overflow from wide signed range checks.
   function automatic res_t model(input logic [1:0] op, input logic [63:0] ra, input logic [63:0] rb);
      res_t r;
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      logic signed [127:0] s;
      sa = {{64{ra[63]}}, ra};
      sb = {{64{rb[63]}}, rb};
      r  = '0;
      case (op)
         2'b00: begin
            r.y = ra + rb;
            r.c = (r.y < ra);
            s   = sa + sb;
            r.v = (s > SMAX) || (s < SMIN);
         end
         2'b01: begin
            r.y = ra - rb;
            r.c = (ra >= rb);
            s   = sa - sb;
            r.v = (s > SMAX) || (s < SMIN);
         end
         2'b10:   r.y = ra & rb;
         default: r.y = ra | rb;
      endcase
      r.z = (r.y == 64'd0);
      r.n = r.y[63];
      return r;
   endfunction

   task automatic check_outputs(input string tag, input res_t e, input logic ev);
      check({tag, ".y"},         y,                 e.y);
      check({tag, ".zero"},      {63'd0, zero},     {63'd0, e.z});
      check({tag, ".negative"},  {63'd0, negative}, {63'd0, e.n});
      check({tag, ".carry"},     {63'd0, carry},    {63'd0, e.c});
      check({tag, ".overflow"},  {63'd0, overflow}, {63'd0, e.v});
      check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ev});
   endtask

   // Drive on the falling edge, let the rising edge capture, check just after it.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [63:0] va,
                        input logic [63:0] vb, input logic valid);
      res_t e;
      @(negedge clk);
      control  = op;
      a        = va;
      b        = vb;
      in_valid = valid;
      e = model(op, va, vb);
      @(posedge clk);
      #1;
      check_outputs(tag, e, valid);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".y"},         y,                  64'd0);
      check({tag, ".zero"},      {63'd0, zero},      64'd1);
      check({tag, ".negative"},  {63'd0, negative},  64'd0);
      check({tag, ".carry"},     {63'd0, carry},     64'd0);
      check({tag, ".overflow"},  {63'd0, overflow},  64'd0);
      check({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   function automatic logic [63:0] rand_operand();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0:       v = 64'd0;
         1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
         2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
         3:       v = 64'h8000_0000_0000_0000;
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      rst_n    = 1'b0;
      control  = 2'b00;
      a        = '0;
      b        = '0;
      in_valid = 1'b0;

      // Held in reset with live random inputs and a running clock.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         control  = 2'($urandom_range(0, 3));
         a        = {$urandom(), $urandom()};
         b        = {$urandom(), $urandom()};
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         check_reset_state($sformatf("rst_hold%0d", i));
      end

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         string tag;
         tag = $sformatf("dir%0d", i);
         do_op(tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].valid);
         if (vecs[i].lit) check({tag, ".lit"}, y, vecs[i].y);
      end

      // Reset asserted between edges must clear outputs without waiting for clk.
      do_op("pre_async", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_state("post_release");
      do_op("after_release", 2'b01, 64'd5, 64'd9, 1'b1);

      for (int i = 0; i < 300; i++) begin
         do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), rand_operand(),
               rand_operand(), ($urandom_range(0, 4) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
